pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline controller for the 5-stage core. It turns the EX-stage jump request, the EX/ALU stall requests, the ID load-use hazard and the external bus wait into per-stage hold and flush controls. It also produces the PC redirect. It sits beside `ex` and drives the stage registers and `pc_reg`. Internal state covers the multi-cycle ALU wait (with a timeout watchdog) and jumps that arrive while the bus is stalled.

## Interface
Parameters:
- ALU_TIMEOUT, 64, max ALU_WAIT cycles before abandoning the stall (≥2)
- CNT_W, $clog2(ALU_TIMEOUT), watchdog counter width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- jump_flag_i  in  1  taken jump/branch from ex
- jump_addr_i  in  32  jump target (InstAddrBus) from ex
- hold_flag_i  in  1  stall request from ex
- alu_busy_i  in  1  multi-cycle ALU operation in progress
- load_use_i  in  1  load-use hazard from id
- bus_hold_i  in  1  memory/bus not ready; freeze whole pipe
- hold_o  out  4  [0] pc, [1] if_id, [2] id_ex, [3] ex_mem hold (keep contents)
- flush_o  out  3  [0] if_id, [1] id_ex, [2] ex_mem load bubble
- jump_flag_o  out  1  PC redirect strobe to pc_reg
- jump_addr_o  out  32  redirect target
- timeout_o  out  1  one-cycle pulse when the ALU watchdog expires

## Operation
- State: FSM {RUN, ALU_WAIT, BUS_WAIT}, counter cnt[CNT_W-1:0], jmp_pend, jmp_addr_q[31:0].
- Outputs are combinational from state, registers and inputs. Unlisted outputs are 0.

RUN, priority order:
1. bus_hold_i:
   - hold_o=4'b1111.
   - If jump_flag_i: jmp_pend<=1, jmp_addr_q<=jump_addr_i.
   - Next state BUS_WAIT.
2. jump_flag_i:
   - jump_flag_o=1, jump_addr_o=jump_addr_i, flush_o=3'b011.
   - Stay in RUN. alu_busy_i, hold_flag_i and load_use_i are ignored this cycle.
3. alu_busy_i | hold_flag_i:
   - hold_o=4'b0111, flush_o=3'b100.
   - cnt<=1, next state ALU_WAIT.
4. load_use_i: hold_o=4'b0011, flush_o=3'b010 (one bubble). Stay in RUN.
5. Otherwise all outputs 0.

ALU_WAIT:
- bus_hold_i: hold_o=4'b1111, cnt frozen, stay.
- Else if alu_busy_i|hold_flag_i:
  - If cnt==ALU_TIMEOUT-1: timeout_o=1, outputs otherwise 0, next state RUN.
  - Else: hold_o=4'b0111, flush_o=3'b100, cnt<=cnt+1.
- Else: all outputs 0 (result enters ex_mem), next state RUN.
- jump_flag_i is ignored in ALU_WAIT.

BUS_WAIT:
- bus_hold_i:
  - hold_o=4'b1111.
  - If jump_flag_i & !jmp_pend: capture it.
  - Once jmp_pend=1, later jump_flag_i values are ignored.
- !bus_hold_i with jmp_pend:
  - jump_flag_o=1, jump_addr_o=jmp_addr_q, flush_o=3'b011.
  - jmp_pend<=0, next state RUN.
- !bus_hold_i without jmp_pend: evaluate as RUN rules 2–5 in this same cycle; next state per those rules.

Reset:
- rst asserted: state=RUN, cnt=0, jmp_pend=0, jmp_addr_q=0.
- All outputs are forced to 0 while rst=1, independent of inputs.
- Reset mid-ALU_WAIT or mid-BUS_WAIT discards the stall and the pending jump.

## Timing
- Zero-cycle latency: holds, flushes and redirect act at the same clock edge that samples the request.
- Jump in RUN: pc loads the target at that edge. if_id and id_ex become bubbles. One redirect strobe per jump.
- Deferred jump: redirect is issued in the first cycle with bus_hold_i=0, never earlier.
- ALU stall of N busy cycles (N<ALU_TIMEOUT): hold_o[2:0] is high for N cycles and drops in cycle N+1.
- Watchdog: timeout_o pulses in the cycle cnt==ALU_TIMEOUT-1 with busy still high. The pipe resumes in that same cycle.
- bus_hold_i cycles do not advance cnt.

## Test plan
- Reset: rst=1 with jump_flag_i=1 and bus_hold_i=1 -> all outputs 0. After release with idle inputs, outputs stay 0.
- Jump: jump_flag_i=1 for 1 cycle, addr 0x0000_0100 -> jump_flag_o=1, jump_addr_o=0x100, flush_o=3'b011 for exactly 1 cycle.
- ALU stall: alu_busy_i high for 3 cycles -> hold_o=4'b0111, flush_o=3'b100 for 3 cycles, then 0. timeout_o stays 0.
- Watchdog: ALU_TIMEOUT=8, alu_busy_i held high -> timeout_o pulses once, in the 8th cycle. Hold releases in that same cycle.
- Deferred jump:
  - Stimulus: bus_hold_i=1 for 4 cycles. jump_flag_i=1 with 0x200 in cycle 2, then 0x300 in cycle 3.
  - Required: hold_o=4'b1111 for 4 cycles. Then one cycle of jump_flag_o=1, addr 0x200, flush_o=3'b011.
- Priority: load_use_i and jump_flag_i asserted together -> jump response only, no hold. Load_use alone -> hold_o=4'b0011, flush_o=3'b010.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage hold/flush and PC redirect control for the 5-stage core.
//
// Ports:
//   clk, rst            core clock; asynchronous active-high reset
//   jump_flag_i/addr_i  taken jump and its target from ex
//   hold_flag_i         stall request from ex
//   alu_busy_i          multi-cycle ALU operation in progress
//   load_use_i          load-use hazard from id
//   bus_hold_i          memory/bus not ready, freeze the whole pipe
//   hold_o[3:0]         keep contents: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem
//   flush_o[2:0]        load bubble:   [0] if_id, [1] id_ex, [2] ex_mem
//   jump_flag_o/addr_o  PC redirect strobe and target to pc_reg
//   timeout_o           one-cycle pulse when the ALU watchdog expires
//
// state    | meaning
// RUN      | normal flow; jumps, stalls and load-use bubbles handled immediately
// ALU_WAIT | multi-cycle ALU/ex stall in progress, cnt counts stall cycles
// BUS_WAIT | whole pipe frozen by the bus; a jump seen meanwhile is parked
module pipe_ctrl #(
  parameter int ALU_TIMEOUT = 64,
  parameter int CNT_W       = $clog2(ALU_TIMEOUT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        alu_busy_i,
  input  logic        load_use_i,
  input  logic        bus_hold_i,
  output logic [3:0]  hold_o,
  output logic [2:0]  flush_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {RUN, ALU_WAIT, BUS_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              jmp_pend, jmp_pend_d;
  logic [31:0]       jmp_addr_q, jmp_addr_d;
  logic              run_eval;
  logic              stall_req;

  assign stall_req = alu_busy_i | hold_flag_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      jmp_pend   <= 1'b0;
      jmp_addr_q <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      jmp_pend   <= jmp_pend_d;
      jmp_addr_q <= jmp_addr_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    jmp_pend_d  = jmp_pend;
    jmp_addr_d  = jmp_addr_q;
    hold_o      = '0;
    flush_o     = '0;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    timeout_o   = 1'b0;
    run_eval    = 1'b0;

    case (state)
      RUN: begin
        if (bus_hold_i) begin
          hold_o  = 4'b1111;
          state_d = BUS_WAIT;
          if (jump_flag_i) begin
            jmp_pend_d = 1'b1;
            jmp_addr_d = jump_addr_i;
          end
        end else begin
          run_eval = 1'b1;
        end
      end
      ALU_WAIT: begin
        if (bus_hold_i) begin
          hold_o = 4'b1111;
        end else if (stall_req) begin
          if (cnt == CNT_LAST) begin
            // abandon the stall; the pipe resumes this cycle
            timeout_o = 1'b1;
            state_d   = RUN;
          end else begin
            hold_o  = 4'b0111;
            flush_o = 3'b100;
            cnt_d   = cnt + 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      BUS_WAIT: begin
        if (bus_hold_i) begin
          hold_o = 4'b1111;
          // only the first jump during a bus stall is kept
          if (jump_flag_i && !jmp_pend) begin
            jmp_pend_d = 1'b1;
            jmp_addr_d = jump_addr_i;
          end
        end else if (jmp_pend) begin
          jump_flag_o = 1'b1;
          jump_addr_o = jmp_addr_q;
          flush_o     = 3'b011;
          jmp_pend_d  = 1'b0;
          state_d     = RUN;
        end else begin
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // RUN priority rules below the bus freeze, shared by RUN and a bus release
    if (run_eval) begin
      if (jump_flag_i) begin
        jump_flag_o = 1'b1;
        jump_addr_o = jump_addr_i;
        flush_o     = 3'b011;
      end else if (stall_req) begin
        hold_o  = 4'b0111;
        flush_o = 3'b100;
        cnt_d   = CNT_W'(1);
        state_d = ALU_WAIT;
      end else if (load_use_i) begin
        hold_o  = 4'b0011;
        flush_o = 3'b010;
      end
    end

    if (rst) begin
      hold_o      = '0;
      flush_o     = '0;
      jump_flag_o = 1'b0;
      jump_addr_o = '0;
      timeout_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic checked
// cycle by cycle against a behavioural model of the stall/jump rules.
module tb_pipe_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i, hold_flag_i, alu_busy_i, load_use_i, bus_hold_i;
  logic [31:0] jump_addr_i;
  logic [3:0]  hold_o;
  logic [2:0]  flush_o;
  logic        jump_flag_o, timeout_o;
  logic [31:0] jump_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: are we inside an ALU stall, how many stall cycles so far,
  // and the jump parked during a bus freeze
  bit          m_stall;
  int          m_len;
  logic [31:0] pend_q[$];
  logic        last_to, last_jf;

  always #5 clk = ~clk;

  pipe_ctrl #(.ALU_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .alu_busy_i(alu_busy_i),
    .load_use_i(load_use_i), .bus_hold_i(bus_hold_i),
    .hold_o(hold_o), .flush_o(flush_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic jf, input logic [31:0] ja,
                      input logic hf, input logic busy, input logic lu, input logic bus);
    logic [3:0]  e_hold;
    logic [2:0]  e_flush;
    logic        e_jf, e_to;
    logic [31:0] e_ja;
    @(negedge clk);
    rst = r; jump_flag_i = jf; jump_addr_i = ja; hold_flag_i = hf;
    alu_busy_i = busy; load_use_i = lu; bus_hold_i = bus;
    #1;
    e_hold = 0; e_flush = 0; e_jf = 0; e_ja = 0; e_to = 0;
    if (r) begin
      m_stall = 0; m_len = 0; pend_q.delete();
    end else if (m_stall) begin
      if (bus) e_hold = 4'hF;
      else if (busy || hf) begin
        if (m_len == T - 1) begin e_to = 1; m_stall = 0; end
        else begin e_hold = 4'b0111; e_flush = 3'b100; m_len++; end
      end else m_stall = 0;
    end else if (bus) begin
      e_hold = 4'hF;
      if (jf && pend_q.size() == 0) pend_q.push_back(ja);
    end else if (pend_q.size() != 0) begin
      e_jf = 1; e_ja = pend_q.pop_front(); e_flush = 3'b011;
    end else if (jf) begin
      e_jf = 1; e_ja = ja; e_flush = 3'b011;
    end else if (busy || hf) begin
      e_hold = 4'b0111; e_flush = 3'b100; m_stall = 1; m_len = 1;
    end else if (lu) begin
      e_hold = 4'b0011; e_flush = 3'b010;
    end
    check("hold",      32'(hold_o),      32'(e_hold));
    check("flush",     32'(flush_o),     32'(e_flush));
    check("jump_flag", 32'(jump_flag_o), 32'(e_jf));
    check("jump_addr", jump_addr_o,      e_ja);
    check("timeout",   32'(timeout_o),   32'(e_to));
    last_to = timeout_o;
    last_jf = jump_flag_o;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    int pulses, pulse_at, jcnt;
    int p_bus, p_busy, p_jf, p_lu, p_hf;
    logic [31:0] addr;
    m_stall = 0; m_len = 0;
    rst = 1; jump_flag_i = 0; jump_addr_i = 0; hold_flag_i = 0;
    alu_busy_i = 0; load_use_i = 0; bus_hold_i = 0;

    // reset forces outputs low regardless of requests
    step(1, 1, 32'h1234, 1, 1, 1, 1);
    step(1, 1, 32'h1234, 0, 0, 0, 0);
    idle(3);

    // single jump
    jcnt = 0;
    step(0, 1, 32'h100, 0, 0, 0, 0); jcnt += int'(last_jf);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0, 0, 0, 0); jcnt += int'(last_jf); end
    check("jump_strobes", 32'(jcnt), 32'd1);

    // 3-cycle ALU stall
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // watchdog: busy for exactly T cycles
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= T; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      if (last_to) begin pulses++; pulse_at = i; end
    end
    idle(2);
    check("wd_pulses", 32'(pulses), 32'd1);
    check("wd_cycle",  32'(pulse_at), 32'(T));

    // deferred jump: only the first one during the freeze survives
    step(0, 0, 0,       0, 0, 0, 1);
    step(0, 1, 32'h200, 0, 0, 0, 1);
    step(0, 1, 32'h300, 0, 0, 0, 1);
    step(0, 0, 0,       0, 0, 0, 1);
    step(0, 0, 0,       0, 0, 0, 0);
    check("deferred_addr", jump_addr_o, 32'h200);
    idle(2);

    // priority and load-use
    step(0, 1, 32'h400, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // bus freeze in the middle of an ALU stall
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(2);

    // reset mid-freeze drops the parked jump
    step(0, 1, 32'h500, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(2);

    // randomized traffic, biased differently per segment
    for (int seg = 0; seg < 8; seg++) begin
      p_bus  = (seg % 2) ? 35 : 10;
      p_busy = (seg >= 4) ? 85 : 30;
      p_jf   = 25; p_lu = 25; p_hf = 10;
      for (int i = 0; i < 250; i++) begin
        addr = $urandom();
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < p_jf), addr,
             ($urandom_range(0, 99) < p_hf),
             ($urandom_range(0, 99) < p_busy),
             ($urandom_range(0, 99) < p_lu),
             ($urandom_range(0, 99) < p_bus));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
